// File: rtl/i2s_tx_pkg.sv
// Shared state encoding and default configuration for the I2S transmit serializer.
package i2s_tx_pkg;

  localparam int unsigned I2S_DATA_WIDTH_DEF = 16;
  localparam int unsigned I2S_SLOT_WIDTH_DEF = 32;
  localparam int unsigned I2S_BCLK_DIV_DEF   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_tx_state_e;

endpackage

// File: rtl/i2s_tx_clkgen.sv
// Bit-clock divider: bclk toggles every BCLK_DIV clk cycles while run is high,
// and fall strobes for the single clk cycle whose edge takes bclk low.
module i2s_tx_clkgen
  import i2s_tx_pkg::*;
#(
  parameter int unsigned BCLK_DIV = I2S_BCLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic bclk,
  output logic fall
);

  localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             div_done;

  assign div_done = (div_cnt == DIV_LAST);
  assign fall     = run && bclk && div_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (div_done) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: holding register, frame bit counter and MSB-first serializer.
// Optional I2S_TX_UNDERRUN_CNT_EN adds a saturating 16-bit underrun_count output.
module i2s_tx_serializer
  import i2s_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = I2S_DATA_WIDTH_DEF,
  parameter int unsigned SLOT_WIDTH = I2S_SLOT_WIDTH_DEF,
  parameter int unsigned BCLK_DIV   = I2S_BCLK_DIV_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic signed [DATA_WIDTH-1:0] audio_left_in,
  input  logic signed [DATA_WIDTH-1:0] audio_right_in,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  output logic                         bclk,
  output logic                         lrclk,
  output logic                         sdata,
  output logic                         underrun,
  output logic                         overrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                  underrun_count
`endif
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int unsigned B_W        = $clog2(FRAME_BITS);
  localparam logic [B_W-1:0] B_LAST   = B_W'(FRAME_BITS - 1);
  localparam logic [B_W-1:0] SLOT_POS = B_W'(SLOT_WIDTH);

  i2s_tx_state_e state, state_next;
  logic          start;
  logic          fall;
  logic          wrap;
  logic          capture;

  logic [B_W-1:0] bit_cnt, bit_next, pos_next;
  logic           lr_next;
  logic           data_bit;

  logic signed [DATA_WIDTH-1:0] hold_left, hold_right;
  logic signed [DATA_WIDTH-1:0] tx_left, tx_right, tx_word;
  logic                         hold_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid) begin
          state_next = RUN;
          start      = 1'b1;
        end
      end
      RUN:     state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  i2s_tx_clkgen #(
    .BCLK_DIV(BCLK_DIV)
  ) u_clkgen (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (state == RUN),
    .bclk   (bclk),
    .fall   (fall)
  );

  assign wrap     = fall && (bit_cnt == B_LAST);
  assign bit_next = (bit_cnt == B_LAST) ? '0 : bit_cnt + 1'b1;
  assign lr_next  = (bit_next >= SLOT_POS);
  assign pos_next = lr_next ? bit_next - SLOT_POS : bit_next;
  assign capture  = sample_valid && !start;

  // Slot position 1 carries the MSB; position 0 and positions past DATA_WIDTH stay 0.
  always_comb begin
    tx_word  = lr_next ? tx_right : tx_left;
    data_bit = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (pos_next == B_W'(DATA_WIDTH - i)) data_bit = tx_word[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      lrclk   <= 1'b0;
      sdata   <= 1'b0;
    end else if (fall) begin
      bit_cnt <= bit_next;
      lrclk   <= lr_next;
      sdata   <= data_bit;
    end
  end

  // The very first pair bypasses the holding register: entering RUN is itself
  // the first frame start (b=0), so it goes straight to the shift registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_left  <= '0;
      hold_right <= '0;
      hold_full  <= 1'b0;
      tx_left    <= '0;
      tx_right   <= '0;
      underrun   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      underrun <= wrap && !hold_full;
      overrun  <= capture && hold_full && !wrap;

      if (start) begin
        tx_left  <= audio_left_in;
        tx_right <= audio_right_in;
      end else if (wrap) begin
        tx_left  <= hold_full ? hold_left  : '0;
        tx_right <= hold_full ? hold_right : '0;
      end

      if (capture) begin
        hold_left  <= audio_left_in;
        hold_right <= audio_right_in;
        hold_full  <= 1'b1;
      end else if (wrap) begin
        hold_full  <= 1'b0;
      end
    end
  end

  assign sample_ready = !hold_full;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun_count <= '0;
    end else if (wrap && !hold_full && (underrun_count != '1)) begin
      underrun_count <= underrun_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Self-checking bench for i2s_tx_serializer; frame contents come from a per-frame model.
module tb_i2s_tx_serializer;

  localparam int unsigned DW        = 16;
  localparam int unsigned SW        = 32;
  localparam int unsigned DIV       = 2;
  localparam int unsigned FB        = 2 * SW;
  localparam int unsigned FRAME_CYC = FB * 2 * DIV;
  localparam logic [63:0] EXP_LR    = {32'hFFFF_FFFF, 32'h0000_0000};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] audio_left_in, audio_right_in;
  logic        sample_valid;
  logic        sample_ready, bclk, lrclk, sdata, underrun, overrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  int          b_mon = 0;
  logic        prev_bclk = 1'b0;
  logic        wrapped = 1'b0;
  logic [63:0] cur_sd = '0, cur_lr = '0, done_sd = '0, done_lr = '0;
  int          under_cnt = 0, over_cnt = 0;

  i2s_tx_serializer #(
    .DATA_WIDTH(DW),
    .SLOT_WIDTH(SW),
    .BCLK_DIV  (DIV)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .audio_left_in (audio_left_in),
    .audio_right_in(audio_right_in),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .bclk          (bclk),
    .lrclk         (lrclk),
    .sdata         (sdata),
    .underrun      (underrun),
    .overrun       (overrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_count(underrun_count)
`endif
  );

  always #5 clk = ~clk;

  // Expected serial frame: bit b of the result is sdata while the bit counter is b.
  function automatic logic [63:0] exp_sd(input logic [15:0] l, input logic [15:0] r);
    logic [63:0] v;
    logic [15:0] w;
    int p;
    v = '0;
    for (int b = 0; b < 64; b++) begin
      p = b % 32;
      w = (b < 32) ? l : r;
      if (p >= 1 && p <= 16) v[b] = w[16-p];
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    wrapped = 1'b0;
    if (prev_bclk && !bclk) begin
      b_mon = (b_mon + 1) % 64;
      if (b_mon == 0) begin
        done_sd = cur_sd;
        done_lr = cur_lr;
        wrapped = 1'b1;
      end
      cur_sd[b_mon] = sdata;
      cur_lr[b_mon] = lrclk;
    end
    prev_bclk = bclk;
    if (underrun) under_cnt++;
    if (overrun)  over_cnt++;
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    audio_left_in  = l;
    audio_right_in = r;
    sample_valid   = 1'b1;
    step();
    sample_valid   = 1'b0;
  endtask

  task automatic mon_start();
    b_mon     = 0;
    cur_sd    = '0;
    cur_lr    = '0;
    cur_sd[0] = sdata;
    cur_lr[0] = lrclk;
  endtask

  task automatic wait_wrap(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!wrapped && n < int'(FRAME_CYC) + 16);
    if (!wrapped) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_wrap_timeout got no frame start within %0d cycles", tag, n);
    end
  endtask

  task automatic test_reset();
    int highs;
    reset_n = 1'b0; sample_valid = 1'b0; audio_left_in = '0; audio_right_in = '0;
    repeat (3) step();
    vectors++; if (bclk !== 1'b0)         begin miscompares++; $display("FAIL rst_bclk got %b want 0", bclk); end
    vectors++; if (lrclk !== 1'b0)        begin miscompares++; $display("FAIL rst_lrclk got %b want 0", lrclk); end
    vectors++; if (sdata !== 1'b0)        begin miscompares++; $display("FAIL rst_sdata got %b want 0", sdata); end
    vectors++; if (sample_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b want 1", sample_ready); end
    vectors++; if (underrun !== 1'b0)     begin miscompares++; $display("FAIL rst_underrun got %b want 0", underrun); end
    vectors++; if (overrun !== 1'b0)      begin miscompares++; $display("FAIL rst_overrun got %b want 0", overrun); end
    reset_n = 1'b1;
    highs = 0;
    repeat (12) begin step(); if (bclk) highs++; end
    vectors++; if (highs != 0) begin miscompares++; $display("FAIL idle_bclk got %0d high cycles want 0", highs); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
    vectors++; if (underrun_count !== 16'd0) begin miscompares++; $display("FAIL rst_ucount got %0d want 0", underrun_count); end
`endif
  endtask

  task automatic test_first_frame();
    logic [63:0] e;
    send(16'h8001, 16'h7FFE);
    mon_start();
    under_cnt = 0; over_cnt = 0;
    vectors++; if (sample_ready !== 1'b1) begin miscompares++; $display("FAIL first_ready got %b want 1", sample_ready); end
    wait_wrap("first");
    e = exp_sd(16'h8001, 16'h7FFE);
    vectors++; if (done_sd !== e)      begin miscompares++; $display("FAIL first_sdata got %h want %h", done_sd, e); end
    vectors++; if (done_lr !== EXP_LR) begin miscompares++; $display("FAIL first_lrclk got %h want %h", done_lr, EXP_LR); end
    vectors++; if (underrun !== 1'b1)  begin miscompares++; $display("FAIL starve_underrun_b0 got %b want 1", underrun); end
    vectors++; if (under_cnt != 1)     begin miscompares++; $display("FAIL starve_underrun_cnt got %0d want 1", under_cnt); end
    step();
    vectors++; if (underrun !== 1'b0)  begin miscompares++; $display("FAIL underrun_width got %b want 0", underrun); end
  endtask

  task automatic test_underrun_frame();
    wait_wrap("starved");
    vectors++; if (done_sd !== 64'h0) begin miscompares++; $display("FAIL starved_sdata got %h want 0", done_sd); end
    vectors++; if (under_cnt != 2)    begin miscompares++; $display("FAIL starved_underrun_cnt got %0d want 2", under_cnt); end
  endtask

  task automatic test_overrun();
    logic [15:0] al, ar, bl, br;
    logic [63:0] e;
    al = 16'($urandom()); ar = 16'($urandom());
    bl = 16'($urandom()); br = 16'($urandom());
    repeat (20) step();
    over_cnt = 0;
    send(al, ar);
    vectors++; if (sample_ready !== 1'b0) begin miscompares++; $display("FAIL ovr_ready got %b want 0", sample_ready); end
    repeat (8) step();
    send(bl, br);
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_pulse got %b want 1", overrun); end
    step();
    vectors++; if (over_cnt != 1)    begin miscompares++; $display("FAIL ovr_cnt got %0d want 1", over_cnt); end
    wait_wrap("ovr_a");
    vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL ovr_no_underrun got %b want 0", underrun); end
    wait_wrap("ovr_b");
    e = exp_sd(bl, br);
    vectors++; if (done_sd !== e) begin miscompares++; $display("FAIL ovr_frame_b got %h want %h", done_sd, e); end
  endtask

  task automatic test_wrap_collision();
    logic [15:0] pl, pr, ql, qr;
    logic [63:0] e;
    int n;
    pl = 16'($urandom()); pr = 16'($urandom());
    ql = 16'($urandom()); qr = 16'($urandom());
    repeat (20) step();
    send(pl, pr);
    n = 0;
    while (!(b_mon == 63 && bclk) && n < int'(FRAME_CYC) + 16) begin step(); n++; end
    repeat (DIV - 1) step();
    over_cnt = 0;
    send(ql, qr);
    vectors++; if (!(wrapped && b_mon == 0)) begin miscompares++; $display("FAIL coll_on_wrap got b=%0d want 0", b_mon); end
    vectors++; if (overrun !== 1'b0)      begin miscompares++; $display("FAIL coll_overrun got %b want 0", overrun); end
    vectors++; if (underrun !== 1'b0)     begin miscompares++; $display("FAIL coll_underrun got %b want 0", underrun); end
    vectors++; if (sample_ready !== 1'b0) begin miscompares++; $display("FAIL coll_ready got %b want 0", sample_ready); end
    wait_wrap("coll_p");
    e = exp_sd(pl, pr);
    vectors++; if (done_sd !== e)     begin miscompares++; $display("FAIL coll_frame_p got %h want %h", done_sd, e); end
    vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL coll_q_loaded got underrun %b want 0", underrun); end
    vectors++; if (over_cnt != 0)     begin miscompares++; $display("FAIL coll_ovr_cnt got %0d want 0", over_cnt); end
    wait_wrap("coll_q");
    e = exp_sd(ql, qr);
    vectors++; if (done_sd !== e) begin miscompares++; $display("FAIL coll_frame_q got %h want %h", done_sd, e); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] nl, nr;
    logic [63:0] e;
    int n, highs;
    repeat (10) step();
    send(16'($urandom()), 16'($urandom()));
    n = 0;
    while (b_mon != 40 && n < int'(FRAME_CYC) + 16) begin step(); n++; end
    vectors++; if (lrclk !== 1'b1 || sample_ready !== 1'b0) begin
      miscompares++; $display("FAIL pre_rst_b40 got lr=%b ready=%b want lr=1 ready=0", lrclk, sample_ready);
    end
    reset_n = 1'b0;
    #1;
    vectors++; if (bclk !== 1'b0)         begin miscompares++; $display("FAIL mid_rst_bclk got %b want 0", bclk); end
    vectors++; if (lrclk !== 1'b0)        begin miscompares++; $display("FAIL mid_rst_lrclk got %b want 0", lrclk); end
    vectors++; if (sdata !== 1'b0)        begin miscompares++; $display("FAIL mid_rst_sdata got %b want 0", sdata); end
    vectors++; if (sample_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready got %b want 1", sample_ready); end
    vectors++; if (underrun !== 1'b0 || overrun !== 1'b0) begin
      miscompares++; $display("FAIL mid_rst_pulses got u=%b o=%b want 0 0", underrun, overrun);
    end
    repeat (3) step();
    reset_n = 1'b1;
    highs = 0;
    repeat (10) begin step(); if (bclk) highs++; end
    vectors++; if (highs != 0) begin miscompares++; $display("FAIL post_rst_idle got %0d bclk highs want 0", highs); end
    nl = 16'($urandom()); nr = 16'($urandom());
    send(nl, nr);
    mon_start();
    wait_wrap("restart");
    e = exp_sd(nl, nr);
    vectors++; if (done_sd !== e)      begin miscompares++; $display("FAIL restart_frame got %h want %h", done_sd, e); end
    vectors++; if (done_lr !== EXP_LR) begin miscompares++; $display("FAIL restart_lrclk got %h want %h", done_lr, EXP_LR); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] xl, xr, pl, pr;
    logic [63:0] e;
    pl = '0; pr = '0;
    for (int i = 0; i < 5; i++) begin
      xl = 16'($urandom()); xr = 16'($urandom());
      repeat ($urandom_range(10, 150)) step();
      send(xl, xr);
      wait_wrap("b2b");
      e = exp_sd(pl, pr);
      vectors++; if (done_sd !== e) begin miscompares++; $display("FAIL b2b_frame%0d got %h want %h", i, done_sd, e); end
      vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL b2b_underrun%0d got %b want 0", i, underrun); end
      pl = xl; pr = xr;
    end
    wait_wrap("b2b_last");
    e = exp_sd(pl, pr);
    vectors++; if (done_sd !== e) begin miscompares++; $display("FAIL b2b_frame_last got %h want %h", done_sd, e); end
  endtask

`ifdef I2S_TX_UNDERRUN_CNT_EN
  task automatic test_underrun_count();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    vectors++; if (underrun_count !== 16'd0) begin miscompares++; $display("FAIL ucnt_reset got %0d want 0", underrun_count); end
    send(16'($urandom()), 16'($urandom()));
    mon_start();
    wait_wrap("ucnt1");
    vectors++; if (underrun_count !== 16'd1) begin miscompares++; $display("FAIL ucnt_1 got %0d want 1", underrun_count); end
    wait_wrap("ucnt2");
    wait_wrap("ucnt3");
    vectors++; if (underrun_count !== 16'd3) begin miscompares++; $display("FAIL ucnt_3 got %0d want 3", underrun_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_frame();
    test_underrun_frame();
    test_overrun();
    test_wrap_collision();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef I2S_TX_UNDERRUN_CNT_EN
    test_underrun_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_tx_serializer.md
I2S_TX_SERIALIZER -- requirements
Module: i2s_tx_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, is the signed sample width per channel.
REQ-002 Parameter SLOT_WIDTH, default 32, is the bclk periods per channel slot; it SHALL be at least DATA_WIDTH+1.
REQ-003 Parameter BCLK_DIV, default 4, is the clk cycles per bclk half-period; it SHALL be at least 1.
REQ-004 Ports SHALL be as follows; one clock, and reset is asynchronous and active-low:
 clk  input  1  system clock; all logic on its rising edge.
 reset_n  input  1  asynchronous active-low reset.
 audio_left_in  input  DATA_WIDTH  signed left sample, e.g. vibrato output.
 audio_right_in  input  DATA_WIDTH  signed right sample.
 sample_valid  input  1  one-clk strobe; the sample pair is valid.
 sample_ready  output  1  high when the holding register is empty.
 bclk  output  1  I2S bit clock.
 lrclk  output  1  word select; 0 = left slot, 1 = right slot.
 sdata  output  1  serial data, MSB first.
 underrun  output  1  one-clk pulse when a frame starts with no fresh sample.
 overrun  output  1  one-clk pulse when sample_valid overwrites an unsent holding pair.

Function
REQ-005 FSM states SHALL be IDLE and RUN; reset enters IDLE; the first sample_valid moves to RUN; there is no other transition.
REQ-006 In IDLE: bclk=0, lrclk=0, sdata=0, and the divider and bit counters are held at 0.
REQ-007 In RUN: bclk SHALL toggle every BCLK_DIV clk cycles, starting high BCLK_DIV cycles after entering RUN.
REQ-008 Bit counter b (0..2*SLOT_WIDTH-1) SHALL advance on every bclk falling transition and wrap to 0.
REQ-009 lrclk and sdata SHALL update only in the clk cycle of a bclk falling transition: lrclk = (b >= SLOT_WIDTH).
REQ-010 Slot position p = b mod SLOT_WIDTH: p=0 drives 0; p=1..DATA_WIDTH drives the sample bit from MSB down to LSB; later positions drive 0.
REQ-011 Holding register: sample_valid captures both channels and marks the register full.
REQ-012 When b wraps to 0, a full holding register SHALL move to the shift registers and be marked empty.
REQ-013 If the holding register is empty at wrap, the shift registers SHALL load 0 and underrun SHALL pulse.
REQ-014 sample_valid on the same cycle as the wrap load SHALL transmit the old holding pair and capture the new pair as full, with no overrun.
REQ-015 sample_valid while full with no load that cycle SHALL overwrite the pair and pulse overrun.
REQ-016 The first sample_valid in IDLE SHALL be captured and loaded at the first frame start (b=0, no underrun).
REQ-017 Latency: capture to MSB on sdata is at most one frame plus two bclk periods.

Reset
REQ-018 reset_n low SHALL immediately force IDLE: bclk=0, lrclk=0, sdata=0, sample_ready=1, underrun=0, overrun=0, and clear all counters and registers, including mid-frame; the frame in progress is lost.

Configuration
REQ-019 Macro I2S_TX_UNDERRUN_CNT_EN defined SHALL add output underrun_count (16 bits), which increments on each underrun pulse, saturates at 65535, and resets to 0.
REQ-020 Without the macro, underrun_count SHALL be absent and the rest of the behaviour is identical.

Structure
REQ-021 Package i2s_tx_pkg SHALL hold the state enum (IDLE, RUN) and the default parameter constants.
REQ-022 Sub-module i2s_tx_clkgen SHALL implement the BCLK_DIV divider and emit bclk plus a one-clk fall strobe.

Verification
REQ-023 The bench SHALL use DATA_WIDTH=16, SLOT_WIDTH=32, BCLK_DIV=2 and cover:
 Reset, then sample_valid with L=16'h8001, R=16'h7FFE -> after the frame start, left p1..16 = 1000000000000001 and right p1..16 = 0111111111111110; p0 and p17..31 = 0.
 Run with no further samples -> underrun pulses once at the next frame start (b=0) and the frame carries all zeros.
 Two sample_valid pulses within one frame (A then B) -> overrun pulses once; the next frame carries B.
 sample_valid on the same cycle as the b=0 load -> the old pair is sent, the new pair is held, and sample_ready=0 with no overrun.
 reset_n low at b=40 -> all outputs go to reset values the same cycle; after release with a new sample, the frame restarts at b=0.
 With I2S_TX_UNDERRUN_CNT_EN defined, 3 starved frames -> underrun_count=3.
